// File: rtl/row_pad_scheduler.sv
// Frame sequencer for the 3-row line-buffer / zero-pad pipeline: walks SIZE+2 padded rows,
// replays each row PASSES times and emits registered sync, valid, read and pad strobes.
module row_pad_scheduler #(
   parameter int unsigned SIZE    = 28,
   parameter int unsigned PASSES  = 2,
   parameter int unsigned GAP     = 0,
   parameter int unsigned PADWAIT = 21,
   parameter int unsigned ROW_W   = $clog2(SIZE + 2),
   parameter int unsigned COL_W   = $clog2(SIZE)
) (
   input  logic             i_sclk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_ready,
   output logic             o_busy,
   output logic             o_vsync,
   output logic             o_hsync,
   output logic             o_valid,
   output logic             o_rdreq,
   output logic             o_reuse,
   output logic             o_pad,
   output logic [ROW_W-1:0] o_row,
   output logic [COL_W-1:0] o_col,
   output logic             o_done
);

   localparam int unsigned CntMax = (GAP > PADWAIT) ? GAP : PADWAIT;
   localparam int unsigned CNT_W  = (CntMax > 1) ? $clog2(CntMax) : 1;
   localparam int unsigned PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

   typedef enum logic [2:0] {
      StIdle, StVsync, StWait, StHsync, StData, StGap, StFlush, StDone
   } state_e;

   state_e            state_q, state_d, row_start_st;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [PASS_W-1:0] pass_q, pass_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              advance;
   logic              strobe_d, valid_d, pad_d, reuse_d;

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      pass_d  = pass_q;
      col_d   = col_q;
      cnt_d   = cnt_q;
      advance = 1'b0;
      // Downstream readiness is sampled on the edge that would launch the hsync cycle.
      row_start_st = i_ready ? StHsync : StWait;

      unique case (state_q)
         StIdle: begin
            if (i_start) begin
               state_d = StVsync;
               row_d   = '0;
               pass_d  = '0;
               col_d   = '0;
               cnt_d   = '0;
            end
         end
         StVsync, StWait: state_d = row_start_st;
         StHsync: begin
            state_d = StData;
            col_d   = '0;
         end
         StData: begin
            if (col_q == COL_W'(SIZE - 1)) begin
               col_d = '0;
               if (GAP > 0) begin
                  state_d = StGap;
                  cnt_d   = '0;
               end else begin
                  advance = 1'b1;
               end
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         StGap: begin
            if (cnt_q == CNT_W'(GAP - 1)) advance = 1'b1;
            else cnt_d = cnt_q + 1'b1;
         end
         StFlush: begin
            if (cnt_q == CNT_W'(PADWAIT - 1)) state_d = StDone;
            else cnt_d = cnt_q + 1'b1;
         end
         StDone: begin
            state_d = StIdle;
            row_d   = '0;
            pass_d  = '0;
         end
         default: state_d = StIdle;
      endcase

      if (advance) begin
         if (pass_q != PASS_W'(PASSES - 1)) begin
            pass_d  = pass_q + 1'b1;
            state_d = row_start_st;
         end else begin
            pass_d = '0;
            if (row_q != ROW_W'(SIZE + 1)) begin
               row_d   = row_q + 1'b1;
               state_d = row_start_st;
            end else if (PADWAIT > 0) begin
               state_d = StFlush;
               cnt_d   = '0;
            end else begin
               state_d = StDone;
            end
         end
      end

      // Outputs are decoded from the next state so every port comes straight from a flop.
      strobe_d = (state_d == StHsync) || (state_d == StData);
      valid_d  = (state_d == StData);
      pad_d    = strobe_d && ((row_d == '0) || (row_d == ROW_W'(SIZE + 1)));
      reuse_d  = strobe_d && (pass_d != '0);
   end

   always_ff @(posedge i_sclk) begin
      if (i_rst) begin
         state_q <= StIdle;
         row_q   <= '0;
         pass_q  <= '0;
         col_q   <= '0;
         cnt_q   <= '0;
         o_busy  <= 1'b0;
         o_vsync <= 1'b0;
         o_hsync <= 1'b0;
         o_valid <= 1'b0;
         o_rdreq <= 1'b0;
         o_reuse <= 1'b0;
         o_pad   <= 1'b0;
         o_row   <= '0;
         o_col   <= '0;
         o_done  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         pass_q  <= pass_d;
         col_q   <= col_d;
         cnt_q   <= cnt_d;
         o_busy  <= (state_d != StIdle);
         o_vsync <= (state_d == StVsync);
         o_hsync <= (state_d == StHsync);
         o_valid <= valid_d;
         o_rdreq <= valid_d && !pad_d && !reuse_d;
         o_reuse <= reuse_d;
         o_pad   <= pad_d;
         o_row   <= row_d;
         o_col   <= valid_d ? col_d : '0;
         o_done  <= (state_d == StDone);
      end
   end

endmodule

// File: tb/tb_row_pad_scheduler.sv
// Bench for row_pad_scheduler: two configurations share stimulus; expected traces come from a
// frame-level model that lays out row-passes by arithmetic over stimulus patterns.
module tb_row_pad_scheduler;

   localparam int MAXC = 512;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, ready;
   logic a_busy, a_vsync, a_hsync, a_valid, a_rdreq, a_reuse, a_pad, a_done;
   logic b_busy, b_vsync, b_hsync, b_valid, b_rdreq, b_reuse, b_pad, b_done;
   logic [2:0] a_row, b_row;
   logic [1:0] a_col, b_col;

   row_pad_scheduler #(.SIZE(4), .PASSES(2), .GAP(1), .PADWAIT(3)) dut_a (
      .i_sclk(clk), .i_rst(rst), .i_start(start), .i_ready(ready),
      .o_busy(a_busy), .o_vsync(a_vsync), .o_hsync(a_hsync), .o_valid(a_valid),
      .o_rdreq(a_rdreq), .o_reuse(a_reuse), .o_pad(a_pad), .o_row(a_row), .o_col(a_col),
      .o_done(a_done)
   );

   row_pad_scheduler #(.SIZE(4), .PASSES(1), .GAP(0), .PADWAIT(0)) dut_b (
      .i_sclk(clk), .i_rst(rst), .i_start(start), .i_ready(ready),
      .o_busy(b_busy), .o_vsync(b_vsync), .o_hsync(b_hsync), .o_valid(b_valid),
      .o_rdreq(b_rdreq), .o_reuse(b_reuse), .o_pad(b_pad), .o_row(b_row), .o_col(b_col),
      .o_done(b_done)
   );

   int errors = 0;
   int checks = 0;
   logic start_pat[MAXC];
   logic ready_pat[MAXC];
   int   rst_cyc;
   // Word: busy vsync hsync valid rdreq reuse pad done | row[15:8] | col[7:0]
   logic [23:0] obs_a[MAXC], obs_b[MAXC], exp_a[MAXC], exp_b[MAXC];

   // Row is only defined while idle or during hsync/valid, so it is masked elsewhere.
   function automatic logic [23:0] word(input logic bu, vs, hs, va, rd, ru, pd, dn,
                                        input logic [7:0] row, input logic [7:0] col);
      logic [7:0] r;
      r = (bu && !hs && !va) ? 8'd0 : row;
      return {bu, vs, hs, va, rd, ru, pd, dn, r, col};
   endfunction

   task automatic clear_pats();
      for (int c = 0; c < MAXC; c++) begin
         start_pat[c] = 1'b0;
         ready_pat[c] = 1'b1;
      end
      rst_cyc = -1;
   endtask

   task automatic go_idle();
      rst = 1'b1; start = 1'b0; ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) begin
         obs_a[c] = word(a_busy, a_vsync, a_hsync, a_valid, a_rdreq, a_reuse, a_pad, a_done,
                         8'(a_row), 8'(a_col));
         obs_b[c] = word(b_busy, b_vsync, b_hsync, b_valid, b_rdreq, b_reuse, b_pad, b_done,
                         8'(b_row), 8'(b_col));
         start = start_pat[c];
         ready = ready_pat[c];
         rst   = (c == rst_cyc);
         @(posedge clk);
         #1;
      end
      start = 1'b0; ready = 1'b1; rst = 1'b0;
   endtask

   task automatic put(input bit sel, input int n, input int s, input int c,
                      input logic [23:0] v);
      if (c < n && !(rst_cyc >= 0 && s < rst_cyc && c > rst_cyc)) begin
         if (sel) exp_b[c] = v;
         else exp_a[c] = v;
      end
   endtask

   // Frame model: accept a start only while idle, then lay out each row-pass back to back,
   // delaying a row-pass start while ready was low in the preceding cycle.
   task automatic build_expected(input bit sel, input int size, input int passes,
                                 input int gap, input int padwait, input int n);
      int cur, s, h, d;
      logic pd, ru;
      for (int c = 0; c < n; c++) begin
         if (sel) exp_b[c] = '0;
         else exp_a[c] = '0;
      end
      cur = 0;
      while (cur < n) begin
         s = cur;
         while (s < n && !(start_pat[s] && s != rst_cyc)) s++;
         if (s >= n) break;
         put(sel, n, s, s + 1, word(1, 1, 0, 0, 0, 0, 0, 0, 8'd0, 8'd0));
         h = s + 2;
         for (int r = 0; r < size + 2; r++) begin
            for (int p = 0; p < passes; p++) begin
               while (h < MAXC && !ready_pat[h - 1]) begin
                  put(sel, n, s, h, word(1, 0, 0, 0, 0, 0, 0, 0, 8'd0, 8'd0));
                  h++;
               end
               pd = (r == 0) || (r == size + 1);
               ru = (p > 0);
               put(sel, n, s, h, word(1, 0, 1, 0, 0, ru, pd, 0, 8'(r), 8'd0));
               for (int k = 0; k < size; k++)
                  put(sel, n, s, h + 1 + k,
                      word(1, 0, 0, 1, !pd && !ru, ru, pd, 0, 8'(r), 8'(k)));
               for (int g = 1; g <= gap; g++)
                  put(sel, n, s, h + size + g, word(1, 0, 0, 0, 0, 0, 0, 0, 8'd0, 8'd0));
               h = h + 1 + size + gap;
            end
         end
         for (int f = 0; f < padwait; f++)
            put(sel, n, s, h + f, word(1, 0, 0, 0, 0, 0, 0, 0, 8'd0, 8'd0));
         d = h + padwait;
         put(sel, n, s, d, word(1, 0, 0, 0, 0, 0, 0, 1, 8'd0, 8'd0));
         if (rst_cyc >= 0 && s < rst_cyc && d > rst_cyc) cur = rst_cyc + 1;
         else cur = d + 1;
      end
   endtask

   task automatic build_both(input int n);
      build_expected(1'b0, 4, 2, 1, 3, n);
      build_expected(1'b1, 4, 1, 0, 0, n);
   endtask

   task automatic test_reset();
      go_idle();
      checks++;
      if (word(a_busy, a_vsync, a_hsync, a_valid, a_rdreq, a_reuse, a_pad, a_done,
               8'(a_row), 8'(a_col)) !== 24'd0) begin
         errors++;
         $display("FAIL reset_a: got busy=%b vsync=%b valid=%b row=%0d, want all 0",
                  a_busy, a_vsync, a_valid, a_row);
      end
      checks++;
      if (word(b_busy, b_vsync, b_hsync, b_valid, b_rdreq, b_reuse, b_pad, b_done,
               8'(b_row), 8'(b_col)) !== 24'd0) begin
         errors++;
         $display("FAIL reset_b: got busy=%b vsync=%b valid=%b row=%0d, want all 0",
                  b_busy, b_vsync, b_valid, b_row);
      end
   endtask

   task automatic test_frame();
      int hs, va, rd, pv, rv, dn, bfirst, blast, hb, rdb, rvb, dnb;
      clear_pats();
      start_pat[0] = 1'b1;
      build_both(100);
      go_idle();
      run(100);
      for (int c = 0; c < 100; c++) begin
         checks += 2;
         if (obs_a[c] !== exp_a[c]) begin
            errors++; $display("FAIL frame_a cyc %0d: got %h want %h", c, obs_a[c], exp_a[c]);
         end
         if (obs_b[c] !== exp_b[c]) begin
            errors++; $display("FAIL frame_b cyc %0d: got %h want %h", c, obs_b[c], exp_b[c]);
         end
      end
      hs = 0; va = 0; rd = 0; pv = 0; rv = 0; dn = -1; bfirst = -1; blast = -1;
      hb = 0; rdb = 0; rvb = 0; dnb = -1;
      for (int c = 0; c < 100; c++) begin
         hs += int'(obs_a[c][21]); va += int'(obs_a[c][20]); rd += int'(obs_a[c][19]);
         pv += int'(obs_a[c][20] & obs_a[c][17]); rv += int'(obs_a[c][20] & obs_a[c][18]);
         if (obs_a[c][16]) dn = c;
         if (obs_a[c][23] && bfirst < 0) bfirst = c;
         if (obs_a[c][23]) blast = c;
         hb += int'(obs_b[c][21]); rdb += int'(obs_b[c][19]); rvb += int'(obs_b[c][18]);
         if (obs_b[c][16]) dnb = c;
      end
      checks += 11;
      if (hs !== 6 * 2) begin errors++; $display("FAIL hsync_count: got %0d want 12", hs); end
      if (va !== 6 * 2 * 4) begin errors++; $display("FAIL valid_count: got %0d want 48", va); end
      if (rd !== 4 * 4) begin errors++; $display("FAIL rdreq_count: got %0d want 16", rd); end
      if (pv !== 2 * 2 * 4) begin errors++; $display("FAIL pad_valid: got %0d want 16", pv); end
      if (rv !== 6 * 4) begin errors++; $display("FAIL reuse_valid: got %0d want 24", rv); end
      if (dn !== 1 + 6 * 2 * 6 + 3 + 1) begin
         errors++; $display("FAIL done_cycle_a: got %0d want 77", dn);
      end
      if (bfirst !== 1 || blast !== 77) begin
         errors++; $display("FAIL busy_span: got %0d..%0d want 1..77", bfirst, blast);
      end
      if (hb !== 6) begin errors++; $display("FAIL hsync_count_b: got %0d want 6", hb); end
      if (rdb !== 16) begin errors++; $display("FAIL rdreq_count_b: got %0d want 16", rdb); end
      if (rvb !== 0) begin errors++; $display("FAIL reuse_b: got %0d want 0", rvb); end
      if (dnb !== 1 + 6 * 5 + 0 + 1) begin
         errors++; $display("FAIL done_cycle_b: got %0d want 32", dnb);
      end
   endtask

   task automatic test_stall();
      int dn, hcyc;
      clear_pats();
      start_pat[0] = 1'b1;
      // Row 2 pass 1 would start at cycle 32; hold ready low across its launch edge.
      for (int c = 31; c <= 35; c++) ready_pat[c] = 1'b0;
      build_both(110);
      go_idle();
      run(110);
      dn = -1; hcyc = -1;
      for (int c = 0; c < 110; c++) begin
         checks += 2;
         if (obs_a[c] !== exp_a[c]) begin
            errors++; $display("FAIL stall_a cyc %0d: got %h want %h", c, obs_a[c], exp_a[c]);
         end
         if (obs_b[c] !== exp_b[c]) begin
            errors++; $display("FAIL stall_b cyc %0d: got %h want %h", c, obs_b[c], exp_b[c]);
         end
         if (obs_a[c][16]) dn = c;
         if (obs_a[c][21] && c > 26 && hcyc < 0) hcyc = c;
      end
      checks += 2;
      if (dn !== 82) begin errors++; $display("FAIL stall_done: got %0d want 82", dn); end
      if (hcyc !== 37) begin errors++; $display("FAIL stall_hsync: got %0d want 37", hcyc); end
   endtask

   task automatic test_ready_mid_row();
      clear_pats();
      start_pat[0] = 1'b1;
      for (int c = 3; c <= 6; c++) ready_pat[c] = c[0];
      ready_pat[15] = 1'b0;
      build_both(100);
      go_idle();
      run(100);
      for (int c = 0; c < 100; c++) begin
         checks += 2;
         if (obs_a[c] !== exp_a[c]) begin
            errors++; $display("FAIL midrow_a cyc %0d: got %h want %h", c, obs_a[c], exp_a[c]);
         end
         if (obs_b[c] !== exp_b[c]) begin
            errors++; $display("FAIL midrow_b cyc %0d: got %h want %h", c, obs_b[c], exp_b[c]);
         end
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (obs_a[3 + k][20] !== 1'b1 || obs_a[3 + k][7:0] !== 8'(k)) begin
            errors++;
            $display("FAIL midrow_col %0d: got valid=%b col=%0d want valid=1 col=%0d", k,
                     obs_a[3 + k][20], obs_a[3 + k][7:0], k);
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_pats();
      start_pat[0] = 1'b1;
      start_pat[30] = 1'b1;
      start_pat[35] = 1'b1;
      rst_cyc = 30;
      build_both(150);
      go_idle();
      run(150);
      for (int c = 0; c < 150; c++) begin
         checks += 2;
         if (obs_a[c] !== exp_a[c]) begin
            errors++; $display("FAIL rstmid_a cyc %0d: got %h want %h", c, obs_a[c], exp_a[c]);
         end
         if (obs_b[c] !== exp_b[c]) begin
            errors++; $display("FAIL rstmid_b cyc %0d: got %h want %h", c, obs_b[c], exp_b[c]);
         end
      end
      checks += 2;
      if (obs_a[31] !== 24'd0) begin
         errors++; $display("FAIL rstmid_clear: got %h want 000000", obs_a[31]);
      end
      if (obs_a[36][22] !== 1'b1) begin
         errors++; $display("FAIL rstmid_vsync: got %b want 1", obs_a[36][22]);
      end
   endtask

   task automatic test_spurious_start();
      int nv, nd;
      clear_pats();
      start_pat[0] = 1'b1; start_pat[10] = 1'b1; start_pat[76] = 1'b1; start_pat[78] = 1'b1;
      build_both(170);
      go_idle();
      run(170);
      nv = 0; nd = 0;
      for (int c = 0; c < 170; c++) begin
         checks += 2;
         if (obs_a[c] !== exp_a[c]) begin
            errors++; $display("FAIL spur_a cyc %0d: got %h want %h", c, obs_a[c], exp_a[c]);
         end
         if (obs_b[c] !== exp_b[c]) begin
            errors++; $display("FAIL spur_b cyc %0d: got %h want %h", c, obs_b[c], exp_b[c]);
         end
         if (c <= 78) begin
            nv += int'(obs_a[c][22]);
            nd += int'(obs_a[c][16]);
         end
      end
      checks += 2;
      if (nv !== 1 || nd !== 1) begin
         errors++; $display("FAIL spur_counts: got vsync=%0d done=%0d want 1 and 1", nv, nd);
      end
      if (obs_a[79][22] !== 1'b1) begin
         errors++; $display("FAIL spur_second_vsync: got %b want 1", obs_a[79][22]);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         clear_pats();
         for (int c = 0; c < 450; c++) begin
            ready_pat[c] = ($urandom_range(0, 4) != 0);
            start_pat[c] = ($urandom_range(0, 29) == 0);
         end
         if ($urandom_range(0, 1) != 0) rst_cyc = int'($urandom_range(20, 400));
         build_both(450);
         go_idle();
         run(450);
         for (int c = 0; c < 450; c++) begin
            checks += 2;
            if (obs_a[c] !== exp_a[c]) begin
               errors++;
               $display("FAIL rand%0d_a cyc %0d: got %h want %h", it, c, obs_a[c], exp_a[c]);
            end
            if (obs_b[c] !== exp_b[c]) begin
               errors++;
               $display("FAIL rand%0d_b cyc %0d: got %h want %h", it, c, obs_b[c], exp_b[c]);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; ready = 1'b1;
      test_reset();
      test_frame();
      test_stall();
      test_ready_mid_row();
      test_reset_mid();
      test_spurious_start();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
